jt12_opslot_ctrl: RTL and testbench
===================================

// Module: jt12_opslot_ctrl
// PURPOSE
//  Per-operator control block for the JT12 FM core: walks the operator/channel
//  slot sequence, holds the 44-bit operator register word per slot, and tracks
//  key-on per slot, including CSM timer-A key-on.
//  Also decodes the algorithm into operator modulation-source selects.
//  It sits between the CPU register interface and the PG/EG/OP pipelines.
// PARAMETERS
//  NUM_CH  6  channel count: 6 (YM2612/YM2608, 24 slots) or 3 (YM2203, 12 slots)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  clk_en     in   1   clock enable; all state advances only when high
//  din        in   8   CPU data byte for operator registers and key-on
//  op         in   2   target operator of a write (0=S1, 1=S3, 2=S2, 3=S4)
//  ch         in   3   target channel of a write (codes 0,1,2,4,5,6)
//  up_dt1,up_tl,up_ks_ar,up_amen_dr,up_sr,up_sl_rr,up_ssgeg  in 1 field write strobes
//  up_keyon   in   1   key-on register write strobe
//  csm        in   1   CSM mode enable
//  overflow_A in   1   timer-A overflow pulse
//  alg_I      in   3   algorithm of the current channel
//  cur_op/cur_ch out 2/3  current slot
//  zero       out  1   registered; high while the current slot is {0,0}
//  s1_enters,s3_enters,s2_enters,s4_enters  out 1  stage strobes
//  tl(7) dt1(3) mul(4) ks(2) ar(5) amsen(1) d1r(5) d2r(5) sl(4) rr(4) ssg_en(1) ssg_eg(3)  out  current-slot fields
//  keyon_I    out  1   key-on state of the current slot
//  xuse_prevprev1,xuse_prev2,xuse_internal,yuse_internal,yuse_prev1,yuse_prev2  out 1  modulation selects
// BEHAVIOUR
//  Reset:
//   - cur_op=0, cur_ch=0, zero=1.
//   - All slot words cleared to 0; all key-on bits cleared; CSM flag cleared.
//  Slot sequence, one step per clk_en:
//   - NUM_CH=6: ch runs 0,1,2,4,5,6 (skips 3 and 7); op increments mod 4 after ch 6.
//   - NUM_CH=3: ch runs 0,1,2; op increments after ch 2.
//   - Period is 24 slots (NUM_CH=6) or 12 slots (NUM_CH=3).
//   - zero is set together with the transition into slot {0,0}.
//  Stage strobes: s1 = cur_op==0, s3 = cur_op==1, s2 = cur_op==2, s4 = cur_op==3.
//  Field writes:
//   - Synchronous, on clk_en, to the slot {op,ch}. Strobes are one-hot.
//   - up_dt1:     dt1=din[6:4], mul=din[3:0]
//   - up_tl:      tl=din[6:0]
//   - up_ks_ar:   ks=din[7:6], ar=din[4:0]
//   - up_amen_dr: amsen=din[7], d1r=din[4:0]
//   - up_sr:      d2r=din[4:0]
//   - up_sl_rr:   sl=din[7:4], rr=din[3:0]
//   - up_ssgeg:   ssg_en=din[3], ssg_eg=din[2:0]
//   - Writes to invalid ch codes (3, 7, or >2 when NUM_CH=3) are ignored.
//  Field outputs: combinational read of the current slot's word. A write is
//   visible the next time that slot is current, including the very next cycle.
//  Key-on:
//   - up_keyon selects channel din[2:0]; invalid channels are ignored.
//   - Sets that channel's slots: din[4]->S1(op0), din[5]->S2(op2), din[6]->S3(op1), din[7]->S4(op3).
//   - A 0 bit keys the slot off.
//  CSM:
//   - overflow_A with csm=1 sets the CSM flag.
//   - While the flag is set, keyon_I is forced 1 for every ch-2 slot.
//   - The flag clears after slot {3,2} has been current.
//   - The stored key-on bits are unchanged by CSM.
//  keyon_I = stored bit of the current slot OR the CSM force.
//  Modulation decode, combinational, with h = onehot(alg_I):
//   - xuse_prevprev1 = s1 | s3&h[5]
//   - xuse_prev2     = s3&(h0|h1|h2) | s4&h3
//   - xuse_internal  = s4&h2
//   - yuse_internal  = s4&(h0|h1|h3|h4)
//   - yuse_prev1     = s1 | s3&h1 | s2&(h0|h3|h4|h5|h6) | s4&(h2|h5)
//   - yuse_prev2     = 0
//  Simultaneous events:
//   - Key-on write and CSM flag in the same cycle: both apply.
//   - Reset mid-sequence returns to slot {0,0} immediately.
//   - clk_en=0 freezes everything, including writes.
// TESTING
//  - Reset, then 25 clk_en cycles, NUM_CH=6 -> slot order {0,0},{0,1},{0,2},{0,4},{0,5},{0,6},{1,0},...; zero high only at {0,0}, cycles 0 and 24.
//  - tl write din=0x7F, op=2, ch=5 -> tl=0x7F only when slot {2,5} is current; every other slot reads 0.
//  - up_keyon din=0xF1 -> keyon_I=1 on all four ch-1 slots; then din=0x01 -> all four 0.
//  - csm=1 plus an overflow_A pulse -> keyon_I=1 on ch-2 slots for one op round, then back to the stored value 0.
//  - alg_I=7, s4 slot -> all modulation selects 0; alg_I=0, s4 slot -> yuse_internal=1.
//  - NUM_CH=3 -> 12-slot period; up_keyon with din[2:0]=4 ignored.

Source files
------------

// File: rtl/jt12_opslot_ctrl_if.sv
// Bus between the CPU/pipeline side and the JT12 operator-slot controller.
// The master drives register writes and timing inputs; the slave returns the current slot state.
interface jt12_opslot_ctrl_if;
    logic [7:0] din;
    logic [1:0] op;
    logic [2:0] ch;
    logic       up_dt1;
    logic       up_tl;
    logic       up_ks_ar;
    logic       up_amen_dr;
    logic       up_sr;
    logic       up_sl_rr;
    logic       up_ssgeg;
    logic       up_keyon;
    logic       csm;
    logic       overflow_A;
    logic [2:0] alg_I;

    logic [1:0] cur_op;
    logic [2:0] cur_ch;
    logic       zero;
    logic       s1_enters;
    logic       s3_enters;
    logic       s2_enters;
    logic       s4_enters;
    logic [6:0] tl;
    logic [2:0] dt1;
    logic [3:0] mul;
    logic [1:0] ks;
    logic [4:0] ar;
    logic       amsen;
    logic [4:0] d1r;
    logic [4:0] d2r;
    logic [3:0] sl;
    logic [3:0] rr;
    logic       ssg_en;
    logic [2:0] ssg_eg;
    logic       keyon_I;
    logic       xuse_prevprev1;
    logic       xuse_prev2;
    logic       xuse_internal;
    logic       yuse_internal;
    logic       yuse_prev1;
    logic       yuse_prev2;

    modport master (
        output din, op, ch, up_dt1, up_tl, up_ks_ar, up_amen_dr, up_sr, up_sl_rr,
               up_ssgeg, up_keyon, csm, overflow_A, alg_I,
        input  cur_op, cur_ch, zero, s1_enters, s3_enters, s2_enters, s4_enters,
               tl, dt1, mul, ks, ar, amsen, d1r, d2r, sl, rr, ssg_en, ssg_eg,
               keyon_I, xuse_prevprev1, xuse_prev2, xuse_internal, yuse_internal,
               yuse_prev1, yuse_prev2
    );

    modport slave (
        input  din, op, ch, up_dt1, up_tl, up_ks_ar, up_amen_dr, up_sr, up_sl_rr,
               up_ssgeg, up_keyon, csm, overflow_A, alg_I,
        output cur_op, cur_ch, zero, s1_enters, s3_enters, s2_enters, s4_enters,
               tl, dt1, mul, ks, ar, amsen, d1r, d2r, sl, rr, ssg_en, ssg_eg,
               keyon_I, xuse_prevprev1, xuse_prev2, xuse_internal, yuse_internal,
               yuse_prev1, yuse_prev2
    );
endinterface

// File: rtl/jt12_opslot_ctrl.sv
// JT12 operator-slot controller: walks the op/channel slot sequence, stores the
// per-slot operator register word and key-on bits, and decodes modulation selects.
module jt12_opslot_ctrl #(
    parameter int NUM_CH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clk_en,
    jt12_opslot_ctrl_if.slave bus
);
    localparam int         NUM_SLOTS = 4 * NUM_CH;
    localparam int         IDX_W     = $clog2(NUM_SLOTS);
    localparam logic [2:0] LAST_CH   = (NUM_CH == 6) ? 3'd6 : 3'd2;

    typedef struct packed {
        logic [2:0] dt1;
        logic [3:0] mul;
        logic [6:0] tl;
        logic [1:0] ks;
        logic [4:0] ar;
        logic       amsen;
        logic [4:0] d1r;
        logic [4:0] d2r;
        logic [3:0] sl;
        logic [3:0] rr;
        logic       ssgEn;
        logic [2:0] ssgEg;
    } slot_word_t;

    slot_word_t             r_word [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   r_keyon;
    logic                   r_csm;
    logic [1:0]             r_curOp;
    logic [2:0]             r_curCh;
    logic                   r_zero;

    logic [1:0]             w_nextOp;
    logic [2:0]             w_nextCh;
    logic [IDX_W-1:0]       w_wrIdx;
    logic                   w_wrOk;
    logic [2:0]             w_konCh;
    logic                   w_konOk;
    logic [IDX_W-1:0]       w_konIdxS1;
    logic [IDX_W-1:0]       w_konIdxS3;
    logic [IDX_W-1:0]       w_konIdxS2;
    logic [IDX_W-1:0]       w_konIdxS4;
    logic [IDX_W-1:0]       w_curIdx;
    slot_word_t             w_cur;
    logic [7:0]             w_algH;
    logic                   w_s1;
    logic                   w_s3;
    logic                   w_s2;
    logic                   w_s4;

    // Channel codes 4..6 pack directly after 0..2, so slots are dense per operator.
    function automatic logic [IDX_W-1:0] slotIdx(input logic [1:0] op, input logic [2:0] ch);
        logic [2:0] chIdx;
        chIdx = (ch > 3'd3) ? ch - 3'd1 : ch;
        return IDX_W'(op) * IDX_W'(NUM_CH) + IDX_W'(chIdx);
    endfunction

    function automatic logic chValid(input logic [2:0] ch);
        if (NUM_CH == 6) begin
            return (ch != 3'd3) && (ch != 3'd7);
        end
        return ch <= 3'd2;
    endfunction

    assign w_wrIdx    = slotIdx(bus.op, bus.ch);
    assign w_wrOk     = chValid(bus.ch);
    assign w_konCh    = bus.din[2:0];
    assign w_konOk    = bus.up_keyon && chValid(w_konCh);
    assign w_konIdxS1 = slotIdx(2'd0, w_konCh);
    assign w_konIdxS3 = slotIdx(2'd1, w_konCh);
    assign w_konIdxS2 = slotIdx(2'd2, w_konCh);
    assign w_konIdxS4 = slotIdx(2'd3, w_konCh);
    assign w_curIdx   = slotIdx(r_curOp, r_curCh);
    assign w_cur      = r_word[w_curIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_curOp <= 2'd0;
            r_curCh <= 3'd0;
            r_zero  <= 1'b1;
        end else if (i_clk_en) begin
            r_curOp <= w_nextOp;
            r_curCh <= w_nextCh;
            r_zero  <= (w_nextOp == 2'd0) && (w_nextCh == 3'd0);
        end
    end

    // With six channels the code after 2 is 4; with three the wrap at 2 comes first.
    always_comb begin
        w_nextOp = r_curOp;
        w_nextCh = r_curCh + 3'd1;
        if (r_curCh == LAST_CH) begin
            w_nextCh = 3'd0;
            w_nextOp = r_curOp + 2'd1;
        end else if (r_curCh == 3'd2) begin
            w_nextCh = 3'd4;
        end
    end

    always_comb begin
        w_s1          = (r_curOp == 2'd0);
        w_s3          = (r_curOp == 2'd1);
        w_s2          = (r_curOp == 2'd2);
        w_s4          = (r_curOp == 2'd3);
        bus.cur_op    = r_curOp;
        bus.cur_ch    = r_curCh;
        bus.zero      = r_zero;
        bus.s1_enters = w_s1;
        bus.s3_enters = w_s3;
        bus.s2_enters = w_s2;
        bus.s4_enters = w_s4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_word[i] <= '0;
            end
        end else if (i_clk_en && w_wrOk) begin
            if (bus.up_dt1) begin
                r_word[w_wrIdx].dt1 <= bus.din[6:4];
                r_word[w_wrIdx].mul <= bus.din[3:0];
            end
            if (bus.up_tl) begin
                r_word[w_wrIdx].tl <= bus.din[6:0];
            end
            if (bus.up_ks_ar) begin
                r_word[w_wrIdx].ks <= bus.din[7:6];
                r_word[w_wrIdx].ar <= bus.din[4:0];
            end
            if (bus.up_amen_dr) begin
                r_word[w_wrIdx].amsen <= bus.din[7];
                r_word[w_wrIdx].d1r   <= bus.din[4:0];
            end
            if (bus.up_sr) begin
                r_word[w_wrIdx].d2r <= bus.din[4:0];
            end
            if (bus.up_sl_rr) begin
                r_word[w_wrIdx].sl <= bus.din[7:4];
                r_word[w_wrIdx].rr <= bus.din[3:0];
            end
            if (bus.up_ssgeg) begin
                r_word[w_wrIdx].ssgEn <= bus.din[3];
                r_word[w_wrIdx].ssgEg <= bus.din[2:0];
            end
        end
    end

    // Key-on data bits map to operators in register order S1,S2,S3,S4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keyon <= '0;
        end else if (i_clk_en && w_konOk) begin
            r_keyon[w_konIdxS1] <= bus.din[4];
            r_keyon[w_konIdxS2] <= bus.din[5];
            r_keyon[w_konIdxS3] <= bus.din[6];
            r_keyon[w_konIdxS4] <= bus.din[7];
        end
    end

    // A new overflow takes precedence over the end-of-round clear at slot {3,2}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csm <= 1'b0;
        end else if (i_clk_en) begin
            if (bus.csm && bus.overflow_A) begin
                r_csm <= 1'b1;
            end else if ((r_curOp == 2'd3) && (r_curCh == 3'd2)) begin
                r_csm <= 1'b0;
            end
        end
    end

    assign bus.dt1     = w_cur.dt1;
    assign bus.mul     = w_cur.mul;
    assign bus.tl      = w_cur.tl;
    assign bus.ks      = w_cur.ks;
    assign bus.ar      = w_cur.ar;
    assign bus.amsen   = w_cur.amsen;
    assign bus.d1r     = w_cur.d1r;
    assign bus.d2r     = w_cur.d2r;
    assign bus.sl      = w_cur.sl;
    assign bus.rr      = w_cur.rr;
    assign bus.ssg_en  = w_cur.ssgEn;
    assign bus.ssg_eg  = w_cur.ssgEg;
    assign bus.keyon_I = r_keyon[w_curIdx] | (r_csm && (r_curCh == 3'd2));

    assign w_algH = 8'd1 << bus.alg_I;

    assign bus.xuse_prevprev1 = w_s1 | (w_s3 & w_algH[5]);
    assign bus.xuse_prev2     = (w_s3 & (w_algH[0] | w_algH[1] | w_algH[2])) | (w_s4 & w_algH[3]);
    assign bus.xuse_internal  = w_s4 & w_algH[2];
    assign bus.yuse_internal  = w_s4 & (w_algH[0] | w_algH[1] | w_algH[3] | w_algH[4]);
    assign bus.yuse_prev1     = w_s1 | (w_s3 & w_algH[1])
                              | (w_s2 & (w_algH[0] | w_algH[3] | w_algH[4] | w_algH[5] | w_algH[6]))
                              | (w_s4 & (w_algH[2] | w_algH[5]));
    assign bus.yuse_prev2     = 1'b0;
endmodule

// File: tb/tb_jt12_opslot_ctrl.sv
// Randomized bench for jt12_opslot_ctrl: a six-channel and a three-channel instance
// are driven identically and compared against a slot-table reference model.
module tb_jt12_opslot_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic clkEn;

    always #5 clk = ~clk;

    jt12_opslot_ctrl_if bus6();
    jt12_opslot_ctrl_if bus3();

    jt12_opslot_ctrl #(.NUM_CH(6)) dut6 (.clk(clk), .rst_n(rst_n), .i_clk_en(clkEn), .bus(bus6));
    jt12_opslot_ctrl #(.NUM_CH(3)) dut3 (.clk(clk), .rst_n(rst_n), .i_clk_en(clkEn), .bus(bus3));

    logic [1:0]  dOp     [2];
    logic [2:0]  dCh     [2];
    logic        dZero   [2];
    logic [3:0]  dStage  [2];
    logic        dKon    [2];
    logic [43:0] dFields [2];
    logic [5:0]  dMod    [2];

    assign dOp[0]     = bus6.cur_op;
    assign dOp[1]     = bus3.cur_op;
    assign dCh[0]     = bus6.cur_ch;
    assign dCh[1]     = bus3.cur_ch;
    assign dZero[0]   = bus6.zero;
    assign dZero[1]   = bus3.zero;
    assign dStage[0]  = {bus6.s1_enters, bus6.s3_enters, bus6.s2_enters, bus6.s4_enters};
    assign dStage[1]  = {bus3.s1_enters, bus3.s3_enters, bus3.s2_enters, bus3.s4_enters};
    assign dKon[0]    = bus6.keyon_I;
    assign dKon[1]    = bus3.keyon_I;
    assign dFields[0] = {bus6.dt1, bus6.mul, bus6.tl, bus6.ks, bus6.ar, bus6.amsen,
                         bus6.d1r, bus6.d2r, bus6.sl, bus6.rr, bus6.ssg_en, bus6.ssg_eg};
    assign dFields[1] = {bus3.dt1, bus3.mul, bus3.tl, bus3.ks, bus3.ar, bus3.amsen,
                         bus3.d1r, bus3.d2r, bus3.sl, bus3.rr, bus3.ssg_en, bus3.ssg_eg};
    assign dMod[0]    = {bus6.xuse_prevprev1, bus6.xuse_prev2, bus6.xuse_internal,
                         bus6.yuse_internal, bus6.yuse_prev1, bus6.yuse_prev2};
    assign dMod[1]    = {bus3.xuse_prevprev1, bus3.xuse_prev2, bus3.xuse_internal,
                         bus3.yuse_internal, bus3.yuse_prev1, bus3.yuse_prev2};

    int nChecks;
    int nErrors;

    // Reference model: slot position counter plus per-{op,ch-code} field and key-on tables.
    int mK     [2];
    int mNch   [2];
    int mField [2][4][8][12];
    int mKon   [2][4][8];
    bit mCsm   [2];

    logic [7:0] curDin;
    logic [1:0] curOp;
    logic [2:0] curCh;
    int         curStrobe;
    logic       curKeyon;
    logic       curCsm;
    logic       curOvf;
    logic [2:0] curAlg;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit chValid(input int c, input int ch);
        if (c == 0) return (ch != 3) && (ch != 7);
        return ch <= 2;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            mK[c]   = 0;
            mCsm[c] = 1'b0;
            for (int o = 0; o < 4; o++) begin
                for (int h = 0; h < 8; h++) begin
                    mKon[c][o][h] = 0;
                    for (int f = 0; f < 12; f++) mField[c][o][h][f] = 0;
                end
            end
        end
    endtask

    task automatic applyField(input int c, input int o, input int h, input int s, input logic [7:0] d);
        case (s)
            1: begin mField[c][o][h][0] = int'(d[6:4]); mField[c][o][h][1] = int'(d[3:0]); end
            2: mField[c][o][h][2] = int'(d[6:0]);
            3: begin mField[c][o][h][3] = int'(d[7:6]); mField[c][o][h][4] = int'(d[4:0]); end
            4: begin mField[c][o][h][5] = int'(d[7]); mField[c][o][h][6] = int'(d[4:0]); end
            5: mField[c][o][h][7] = int'(d[4:0]);
            6: begin mField[c][o][h][8] = int'(d[7:4]); mField[c][o][h][9] = int'(d[3:0]); end
            7: begin mField[c][o][h][10] = int'(d[3]); mField[c][o][h][11] = int'(d[2:0]); end
            default: ;
        endcase
    endtask

    task automatic modelStep();
        int o;
        int h;
        int kc;
        if (!clkEn) return;
        for (int c = 0; c < 2; c++) begin
            o = mK[c] / mNch[c];
            h = mK[c] % mNch[c];
            if (h >= 3) h = h + 1;
            if (curStrobe != 0 && chValid(c, int'(curCh))) applyField(c, int'(curOp), int'(curCh), curStrobe, curDin);
            kc = int'(curDin[2:0]);
            if (curKeyon && chValid(c, kc)) begin
                mKon[c][0][kc] = int'(curDin[4]);
                mKon[c][2][kc] = int'(curDin[5]);
                mKon[c][1][kc] = int'(curDin[6]);
                mKon[c][3][kc] = int'(curDin[7]);
            end
            if (curCsm && curOvf) mCsm[c] = 1'b1;
            else if (o == 3 && h == 2) mCsm[c] = 1'b0;
            mK[c] = (mK[c] + 1) % (4 * mNch[c]);
        end
    endtask

    task automatic checkAll();
        int o;
        int h;
        int a;
        bit s1, s3, s2, s4;
        logic [43:0] expF;
        logic [5:0]  expM;
        string nm;
        for (int c = 0; c < 2; c++) begin
            nm = (c == 0) ? "ch6" : "ch3";
            o  = mK[c] / mNch[c];
            h  = mK[c] % mNch[c];
            if (h >= 3) h = h + 1;
            a  = int'(curAlg);
            s1 = (o == 0); s3 = (o == 1); s2 = (o == 2); s4 = (o == 3);
            expF = {3'(mField[c][o][h][0]), 4'(mField[c][o][h][1]), 7'(mField[c][o][h][2]),
                    2'(mField[c][o][h][3]), 5'(mField[c][o][h][4]), 1'(mField[c][o][h][5]),
                    5'(mField[c][o][h][6]), 5'(mField[c][o][h][7]), 4'(mField[c][o][h][8]),
                    4'(mField[c][o][h][9]), 1'(mField[c][o][h][10]), 3'(mField[c][o][h][11])};
            expM[5] = s1 | (s3 && a == 5);
            expM[4] = (s3 && a <= 2) | (s4 && a == 3);
            expM[3] = s4 && a == 2;
            expM[2] = s4 && (a == 0 || a == 1 || a == 3 || a == 4);
            expM[1] = s1 | (s3 && a == 1) | (s2 && (a == 0 || (a >= 3 && a <= 6))) | (s4 && (a == 2 || a == 5));
            expM[0] = 1'b0;
            checkOutput({nm, ".cur_op"}, 64'(dOp[c]), 64'(o));
            checkOutput({nm, ".cur_ch"}, 64'(dCh[c]), 64'(h));
            checkOutput({nm, ".zero"}, 64'(dZero[c]), 64'(mK[c] == 0));
            checkOutput({nm, ".stage"}, 64'(dStage[c]), 64'({s1, s3, s2, s4}));
            checkOutput({nm, ".keyon_I"}, 64'(dKon[c]), 64'((mKon[c][o][h] != 0) || (mCsm[c] && h == 2)));
            checkOutput({nm, ".fields"}, 64'(dFields[c]), 64'(expF));
            checkOutput({nm, ".modsel"}, 64'(dMod[c]), 64'(expM));
        end
    endtask

    task automatic driveBus();
        bus6.din = curDin;         bus3.din = curDin;
        bus6.op = curOp;           bus3.op = curOp;
        bus6.ch = curCh;           bus3.ch = curCh;
        bus6.up_dt1 = (curStrobe == 1);     bus3.up_dt1 = (curStrobe == 1);
        bus6.up_tl = (curStrobe == 2);      bus3.up_tl = (curStrobe == 2);
        bus6.up_ks_ar = (curStrobe == 3);   bus3.up_ks_ar = (curStrobe == 3);
        bus6.up_amen_dr = (curStrobe == 4); bus3.up_amen_dr = (curStrobe == 4);
        bus6.up_sr = (curStrobe == 5);      bus3.up_sr = (curStrobe == 5);
        bus6.up_sl_rr = (curStrobe == 6);   bus3.up_sl_rr = (curStrobe == 6);
        bus6.up_ssgeg = (curStrobe == 7);   bus3.up_ssgeg = (curStrobe == 7);
        bus6.up_keyon = curKeyon;  bus3.up_keyon = curKeyon;
        bus6.csm = curCsm;         bus3.csm = curCsm;
        bus6.overflow_A = curOvf;  bus3.overflow_A = curOvf;
        bus6.alg_I = curAlg;       bus3.alg_I = curAlg;
    endtask

    // One cycle: drive, check current slot before the edge, then advance the model.
    task automatic applyStimulus(input logic en, input logic [7:0] din, input logic [1:0] op,
                                 input logic [2:0] ch, input int strobe, input logic keyon,
                                 input logic csm, input logic ovf, input logic [2:0] alg);
        clkEn = en; curDin = din; curOp = op; curCh = ch; curStrobe = strobe;
        curKeyon = keyon; curCsm = csm; curOvf = ovf; curAlg = alg;
        driveBus();
        #1;
        checkAll();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n, input logic csm, input logic [2:0] alg);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'h00, 2'd0, 3'd0, 0, 1'b0, csm, 1'b0, alg);
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, 8'($urandom), 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) < 5) ? int'($urandom_range(1, 7)) : 0,
                          $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        mNch[0] = 6;
        mNch[1] = 3;
        clkEn = 1'b0; curDin = '0; curOp = '0; curCh = '0; curStrobe = 0;
        curKeyon = 1'b0; curCsm = 1'b0; curOvf = 1'b0; curAlg = 3'd7;
        driveBus();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkAll();
        rst_n = 1'b1;

        idle(25, 1'b0, 3'd7);
        applyStimulus(1'b1, 8'h7F, 2'd2, 3'd5, 2, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(25, 1'b0, 3'd0);
        applyStimulus(1'b1, 8'hF1, 2'd0, 3'd0, 0, 1'b1, 1'b0, 1'b0, 3'd3);
        idle(24, 1'b0, 3'd3);
        applyStimulus(1'b1, 8'h01, 2'd0, 3'd0, 0, 1'b1, 1'b0, 1'b0, 3'd5);
        idle(24, 1'b0, 3'd5);
        applyStimulus(1'b1, 8'h00, 2'd0, 3'd0, 0, 1'b0, 1'b1, 1'b1, 3'd2);
        idle(40, 1'b1, 3'd2);
        applyStimulus(1'b1, 8'hF4, 2'd0, 3'd0, 0, 1'b1, 1'b0, 1'b0, 3'd1);
        idle(24, 1'b0, 3'd4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'hFF, 2'd1, 3'd1, 2, 1'b1, 1'b1, 1'b1, 3'd6);
        idle(24, 1'b0, 3'd6);

        randomCycles(1500);

        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        #2;
        rst_n = 1'b1;
        randomCycles(800);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
